// File: rtl/fg_cordic_seq.sv
// Iterative CORDIC engine: one shared micro-rotation stage reused over ITERATIONS
// cycles, rotation (sin/cos) or vectoring (magnitude/phase), valid/ready both sides.
module fg_cordic_seq #(
  parameter int BITWIDTH       = 8,
  parameter int BITWIDTH_PHASE = 10,
  parameter int ITERATIONS     = 7
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clk_en_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic                             mode_i,
  input  logic signed [BITWIDTH_PHASE-1:0] phase_i,
  input  logic signed [BITWIDTH-1:0]       x_i,
  input  logic signed [BITWIDTH-1:0]       y_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic signed [BITWIDTH+1:0]       x_o,
  output logic signed [BITWIDTH+1:0]       y_o,
  output logic signed [BITWIDTH_PHASE-1:0] phase_o
);

  localparam int W       = BITWIDTH + 2;
  localparam int P       = BITWIDTH_PHASE;
  localparam int KW      = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int ATAN_SH = 24 - P;
  localparam int RND_SH  = (ATAN_SH > 0) ? ATAN_SH - 1 : 0;

  localparam logic [KW-1:0]       K_LAST = KW'(ITERATIONS - 1);
  localparam logic signed [P-1:0] QTR    = {2'b01, {(P-2){1'b0}}};
  localparam logic signed [P-1:0] NQTR   = {2'b11, {(P-2){1'b0}}};

  // atan(2^-k) in units of 45 deg, scaled by 2^21; reduced to the phase width below
  localparam int ATAN_2P21 [16] = '{
    2097152, 1238021, 654136, 332050, 166669, 83416, 41718, 20860,
    10430,   5215,    2608,   1304,   652,    326,   163,   81
  };

  function automatic logic signed [P-1:0] atan_of(input logic [3:0] idx);
    longint v;
    v = longint'(ATAN_2P21[idx]);
    if (ATAN_SH > 0) v = (v + (longint'(1) <<< RND_SH)) >>> ATAN_SH;
    return v[P-1:0];
  endfunction

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  typedef struct packed {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [P-1:0] z;
  } vec_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic                mode_q;
  vec_t                cur_q;
  vec_t                ld;
  vec_t                nx;
  logic signed [W-1:0] xe;
  logic signed [W-1:0] ye;
  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic signed [P-1:0] atan_k;
  logic                dir;
  logic                accept;

  assign ready_o = !rst_i && ((state_q == IDLE) || ((state_q == DONE) && ready_i));
  assign accept  = valid_i && ready_o && clk_en_i;

  // Pre-rotate into the right half-plane so the micro-rotations only cover +-90 deg
  always_comb begin
    xe   = {{2{x_i[BITWIDTH-1]}}, x_i};
    ye   = {{2{y_i[BITWIDTH-1]}}, y_i};
    ld.x = xe;
    ld.y = ye;
    ld.z = phase_i;
    if (!mode_i) begin
      if (phase_i[P-1:P-2] == 2'b01) begin
        ld.x = -ye;
        ld.y = xe;
        ld.z = {2'b00, phase_i[P-3:0]};
      end else if (phase_i[P-1:P-2] == 2'b10) begin
        ld.x = ye;
        ld.y = -xe;
        ld.z = {2'b11, phase_i[P-3:0]};
      end
    end else begin
      ld.z = '0;
      if (xe[W-1]) begin
        if (!ye[W-1]) begin
          ld.x = ye;
          ld.y = -xe;
          ld.z = QTR;
        end else begin
          ld.x = -ye;
          ld.y = xe;
          ld.z = NQTR;
        end
      end
    end
  end

  always_comb begin
    x_sh   = cur_q.x >>> k_q;
    y_sh   = cur_q.y >>> k_q;
    atan_k = atan_of(4'(k_q));
    dir    = mode_q ? !cur_q.y[W-1] : cur_q.z[P-1];
    nx.x   = dir ? cur_q.x + y_sh : cur_q.x - y_sh;
    nx.y   = dir ? cur_q.y - x_sh : cur_q.y + x_sh;
    nx.z   = dir ? cur_q.z + atan_k : cur_q.z - atan_k;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      mode_q  <= 1'b0;
      cur_q   <= '0;
      valid_o <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      phase_o <= '0;
    end else if (clk_en_i) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= ROTATE;
            k_q     <= '0;
            mode_q  <= mode_i;
            cur_q   <= ld;
          end
        end
        ROTATE: begin
          cur_q <= nx;
          if (k_q == K_LAST) begin
            state_q <= DONE;
            k_q     <= '0;
            valid_o <= 1'b1;
            x_o     <= nx.x;
            y_o     <= nx.y;
            phase_o <= nx.z;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            // a new request may be taken on the same edge as the handoff
            if (accept) begin
              state_q <= ROTATE;
              k_q     <= '0;
              mode_q  <= mode_i;
              cur_q   <= ld;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_cordic_seq.sv
// Bench for fg_cordic_seq: directed angles, random operands against an integer
// CORDIC model, backpressure, clock-enable gaps, back-to-back and mid-op reset.
module tb_fg_cordic_seq;
  localparam int BW   = 8;
  localparam int PW   = 10;
  localparam int IT   = 7;
  localparam int OW   = BW + 2;
  localparam int FULL = 1 << PW;
  localparam int HALF = 1 << (PW - 1);
  localparam int QTR  = 1 << (PW - 2);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b1;
  logic                 vin = 1'b0;
  logic                 rin = 1'b0;
  logic                 mode = 1'b0;
  logic signed [PW-1:0] ph = '0;
  logic signed [BW-1:0] xi = '0;
  logic signed [BW-1:0] yi = '0;
  logic                 ready_o;
  logic                 valid_o;
  logic signed [OW-1:0] x_o;
  logic signed [OW-1:0] y_o;
  logic signed [PW-1:0] phase_o;

  int n_cmp = 0;
  int n_bad = 0;
  int atn [16];

  fg_cordic_seq #(.BITWIDTH(BW), .BITWIDTH_PHASE(PW), .ITERATIONS(IT)) dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en), .valid_i(vin), .ready_o(ready_o),
    .mode_i(mode), .phase_i(ph), .x_i(xi), .y_i(yi), .valid_o(valid_o),
    .ready_i(rin), .x_o(x_o), .y_o(y_o), .phase_o(phase_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrapz(input int v);
    int r;
    r = v;
    while (r >= HALF) r = r - FULL;
    while (r < -HALF) r = r + FULL;
    return r;
  endfunction

  // Textbook CORDIC on plain integers; angles in units where a full turn is FULL.
  task automatic model(input bit m, input int p, input int x0, input int y0,
                       output int xr, output int yr, output int zr);
    int x, y, z, xt;
    bit d;
    if (!m) begin
      if (p >= QTR)       begin x = -y0; y = x0;  z = p - QTR; end
      else if (p < -QTR)  begin x = y0;  y = -x0; z = p + QTR; end
      else                begin x = x0;  y = y0;  z = p;       end
    end else if (x0 >= 0) begin x = x0;  y = y0;  z = 0;    end
    else if (y0 >= 0)     begin x = y0;  y = -x0; z = QTR;  end
    else                  begin x = -y0; y = x0;  z = -QTR; end
    for (int k = 0; k < IT; k++) begin
      d  = m ? (y >= 0) : (z < 0);
      xt = x;
      if (d) begin x = x + (y >>> k); y = y - (xt >>> k); z = wrapz(z + atn[k]); end
      else   begin x = x - (y >>> k); y = y + (xt >>> k); z = wrapz(z - atn[k]); end
    end
    xr = x; yr = y; zr = z;
  endtask

  task automatic start_op(input bit m, input int p, input int x, input int y);
    mode = m;
    ph   = p[PW-1:0];
    xi   = x[BW-1:0];
    yi   = y[BW-1:0];
    vin  = 1'b1;
    tick();
    vin  = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (valid_o === 1'b1) begin ok = 1'b1; break; end
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    rin = 1'b1;
    tick();
    rin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", ready_o); end
    n_cmp++;
    if (valid_o !== 1'b0 || x_o !== '0 || y_o !== '0 || phase_o !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b x=%0d y=%0d p=%0d want all 0", valid_o, x_o, y_o, phase_o);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready_release: got %b want 1", ready_o); end
  endtask

  task automatic test_directed();
    int dm [6] = '{0, 0, 0, 0, 1, 1};
    int dp [6] = '{0, 256, -512, 128, 0, 0};
    int dx [6] = '{100, 100, 100, 100, -100, -128};
    int dy [6] = '{0, 0, 0, 0, 100, -128};
    int ax [6] = '{165, 0, -165, 116, 233, 298};
    int ay [6] = '{0, 165, 0, 116, 0, 0};
    int az [6] = '{0, 0, 0, 0, 384, -384};
    int lat, ex, ey, ez, gx, gy, gz;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      model(dm[i][0], dp[i], dx[i], dy[i], ex, ey, ez);
      start_op(dm[i][0], dp[i], dx[i], dy[i]);
      wait_valid(lat, ok);
      n_cmp++;
      if (!ok || lat !== IT) begin n_bad++; $display("FAIL dir%0d_latency: got %0d ok=%b want %0d", i, lat, ok, IT); end
      gx = x_o; gy = y_o; gz = phase_o;
      n_cmp++;
      if (gx !== ex || gy !== ey || gz !== ez) begin
        n_bad++;
        $display("FAIL dir%0d_exact: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, gx, gy, gz, ex, ey, ez);
      end
      n_cmp++;
      if (gx - ax[i] > 3 || ax[i] - gx > 3 || gy - ay[i] > 3 || ay[i] - gy > 3 ||
          gz - az[i] > 3 || az[i] - gz > 3) begin
        n_bad++;
        $display("FAIL dir%0d_approx: got (%0d,%0d,%0d) want ~(%0d,%0d,%0d) +-3", i, gx, gy, gz, ax[i], ay[i], az[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    int lat, p, x, y, ex, ey, ez, gx, gy, gz;
    bit m, ok;
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom % 2);
      p = int'($urandom_range(0, FULL - 1)) - HALF;
      x = int'($urandom_range(0, 255)) - 128;
      y = int'($urandom_range(0, 255)) - 128;
      if ($urandom % 6 == 0) x = -128;
      if ($urandom % 6 == 0) y = -128;
      model(m, p, x, y, ex, ey, ez);
      start_op(m, p, x, y);
      wait_valid(lat, ok);
      gx = x_o; gy = y_o; gz = phase_o;
      n_cmp++;
      if (!ok || gx !== ex || gy !== ey || gz !== ez) begin
        n_bad++;
        $display("FAIL rnd%0d m=%0d p=%0d in=(%0d,%0d): got (%0d,%0d,%0d) ok=%b want (%0d,%0d,%0d)",
                 i, m, p, x, y, gx, gy, gz, ok, ex, ey, ez);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat, ax, ay, az, bx, by, bz, gx, gy, gz;
    bit ok;
    model(1'b0, 300, 77, -50, ax, ay, az);
    model(1'b1, 0, -90, 35, bx, by, bz);
    start_op(1'b0, 300, 77, -50);
    wait_valid(lat, ok);
    mode = 1'b1; ph = '0; xi = -8'sd90; yi = 8'sd35; vin = 1'b1;
    for (int c = 0; c < 5; c++) begin
      gx = x_o; gy = y_o; gz = phase_o;
      n_cmp++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || gx !== ax || gy !== ay || gz !== az) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b r=%b (%0d,%0d,%0d) want v=1 r=0 (%0d,%0d,%0d)",
                 c, valid_o, ready_o, gx, gy, gz, ax, ay, az);
      end
      tick();
    end
    rin = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_follows: got %b want 1", ready_o); end
    tick();
    vin = 1'b0;
    rin = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_handoff: got v=%b r=%b want v=0 r=0", valid_o, ready_o);
    end
    wait_valid(lat, ok);
    gx = x_o; gy = y_o; gz = phase_o;
    n_cmp++;
    if (!ok || lat !== IT || gx !== bx || gy !== by || gz !== bz) begin
      n_bad++;
      $display("FAIL bp_next: got lat=%0d (%0d,%0d,%0d) want lat=%0d (%0d,%0d,%0d)", lat, gx, gy, gz, IT, bx, by, bz);
    end
    release_result();
  endtask

  task automatic test_clk_en();
    int ex, ey, ez, gx, gy, gz, cnt;
    model(1'b0, 200, 90, -40, ex, ey, ez);
    mode = 1'b0; ph = 10'sd200; xi = 8'sd90; yi = -8'sd40;
    en = 1'b0; vin = 1'b1;
    tick();
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL en_no_accept: got ready %b want 1", ready_o); end
    en = 1'b1;
    tick();
    vin = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (valid_o === 1'b1) break;
      en = 1'($urandom % 2);
      tick();
      if (en) cnt++;
    end
    en = 1'b1;
    gx = x_o; gy = y_o; gz = phase_o;
    n_cmp++;
    if (valid_o !== 1'b1 || cnt !== IT || gx !== ex || gy !== ey || gz !== ez) begin
      n_bad++;
      $display("FAIL en_gaps: got v=%b en_edges=%0d (%0d,%0d,%0d) want v=1 %0d (%0d,%0d,%0d)",
               valid_o, cnt, gx, gy, gz, IT, ex, ey, ez);
    end
    en = 1'b0; rin = 1'b1;
    tick();
    n_cmp++;
    if (valid_o !== 1'b1) begin n_bad++; $display("FAIL en_done_hold: got valid %b want 1", valid_o); end
    en = 1'b1;
    tick();
    rin = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL en_done_release: got valid %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    int bm [3] = '{0, 1, 0};
    int bp [3] = '{-100, 0, 450};
    int bx [3] = '{60, 40, -127};
    int by [3] = '{20, -110, 5};
    int lat, ex, ey, ez, gx, gy, gz;
    bit ok;
    mode = bm[0][0]; ph = bp[0][PW-1:0]; xi = bx[0][BW-1:0]; yi = by[0][BW-1:0];
    vin = 1'b1; rin = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      model(bm[i][0], bp[i], bx[i], by[i], ex, ey, ez);
      if (i < 2) begin
        mode = bm[i+1][0]; ph = bp[i+1][PW-1:0]; xi = bx[i+1][BW-1:0]; yi = by[i+1][BW-1:0];
      end else begin
        vin = 1'b0;
      end
      wait_valid(lat, ok);
      gx = x_o; gy = y_o; gz = phase_o;
      n_cmp++;
      if (!ok || lat !== IT || gx !== ex || gy !== ey || gz !== ez) begin
        n_bad++;
        $display("FAIL b2b%0d: got lat=%0d (%0d,%0d,%0d) want lat=%0d (%0d,%0d,%0d)", i, lat, gx, gy, gz, IT, ex, ey, ez);
      end
      tick();
    end
    rin = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, ex, ey, ez, gx, gy, gz;
    bit ok, quiet;
    start_op(1'b0, 0, 100, 0);
    wait_valid(lat, ok);
    release_result();
    start_op(1'b1, 0, 50, 70);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", ready_o); end
    tick();
    rst = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || x_o !== '0 || y_o !== '0 || phase_o !== '0) begin
      n_bad++;
      $display("FAIL mid_rst_outputs: got v=%b (%0d,%0d,%0d) want 0", valid_o, x_o, y_o, phase_o);
    end
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_rst_release: got %b want 1", ready_o); end
    quiet = 1'b1;
    for (int i = 0; i < IT + 2; i++) begin
      tick();
      if (valid_o !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin n_bad++; $display("FAIL mid_rst_discard: got stray valid want none"); end
    model(1'b1, 0, 50, 70, ex, ey, ez);
    start_op(1'b1, 0, 50, 70);
    wait_valid(lat, ok);
    gx = x_o; gy = y_o; gz = phase_o;
    n_cmp++;
    if (!ok || lat !== IT || gx !== ex || gy !== ey || gz !== ez) begin
      n_bad++;
      $display("FAIL mid_rst_next: got lat=%0d (%0d,%0d,%0d) want lat=%0d (%0d,%0d,%0d)", lat, gx, gy, gz, IT, ex, ey, ez);
    end
    release_result();
  endtask

  initial begin
    real    a;
    longint t;
    for (int k = 0; k < 16; k++) begin
      a = $atan(1.0 / (2.0 ** k)) * 4.0 / 3.14159265358979323846 * (2.0 ** 21);
      t = longint'(a);
      atn[k] = int'((t + (longint'(1) <<< (24 - PW - 1))) >>> (24 - PW));
    end
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_clk_en();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
